// File: rtl/sub_arbiter.sv
// sub_arbiter: two requesters share one WIDTH-bit subtractor.
// A winner is granted in IDLE, its operands are registered, the difference
// with carry-out (1 = no borrow) is formed in EXEC and held in RESP until the
// consumer takes it.
// Optional feature macro: SUB_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (pointer toggles on every accept); without it requester 0 has fixed priority.
module sub_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_num1,
  input  logic [WIDTH-1:0] req0_num2,
  input  logic [WIDTH-1:0] req1_num1,
  input  logic [WIDTH-1:0] req1_num2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sout,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] num1_p0;
  logic [WIDTH-1:0] num2_p0;
  logic             id_p0;

  // Two's-complement subtract: a + ~b + 1, keeping the carry-out as the MSB.
  function automatic logic [WIDTH:0] sub_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

`ifdef SUB_ARB_ROUND_ROBIN_EN
  logic ptr;

  // Pick the winner: the pointer only matters when both requesters are valid.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else                    grant = req_valid;
  end

  // Preferred requester flips on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (accept) ptr <= ~ptr;
  end
`else
  // Pick the winner: requester 0 always has priority.
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`endif

  assign accept = (state == IDLE) && (grant != 2'b00);
  assign busy   = (state != IDLE);

  // Next-state and grant outputs; requests are only offered ready in IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        req_ready = rst ? 2'b00 : grant;
        if (grant != 2'b00) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: capture the winning operand pair and its ID on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0   <= grant[1];
      num1_p0 <= grant[1] ? req1_num1 : req0_num1;
      num2_p0 <= grant[1] ? req1_num2 : req0_num2;
    end
  end

  // Result stage: compute in EXEC, hold through RESP, count completed handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sout  <= '0;
      res_id    <= 1'b0;
      op_count  <= '0;
    end else begin
      if (state == EXEC) begin
        res_sout  <= sub_carry(num1_p0, num2_p0);
        res_id    <= id_p0;
        res_valid <= 1'b1;
      end else if (state == RESP && res_ready) begin
        res_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: directed cases followed by random
// traffic, all results checked by a scoreboard fed from a transaction model.
module tb_sub_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req0_num1, req0_num2, req1_num1, req1_num2;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res_sout;
  logic        res_id;
  logic        busy;
  logic [15:0] op_count;

  sub_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_num1(req0_num1), .req0_num2(req0_num2),
    .req1_num1(req1_num1), .req1_num2(req1_num2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sout(res_sout), .res_id(res_id),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration rule.
  function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic p);
`ifdef SUB_ARB_ROUND_ROBIN_EN
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
`else
    if (v[0]) return 2'b01;
    if (v[1]) return 2'b10;
    return {1'b0, p & 1'b0};
`endif
  endfunction

  // Reference arithmetic: carry = no borrow, low bits = difference mod 256.
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {(a >= b), d};
  endfunction

  typedef struct {
    logic       id;
    logic [8:0] sout;
    int         acc;
  } exp_t;

  exp_t        q[$];
  bit          m_idle = 1'b1;
  logic        m_ptr  = 1'b0;
  logic [15:0] m_cnt  = '0;
  bit          shown  = 1'b0;
  int          cyc    = 0;
  bit          acc_pulse = 1'b0;
  logic        acc_id    = 1'b0;

  // Model + monitor: evaluated on the falling edge, predicting the next rising edge.
  always @(negedge clk) begin
    logic [1:0] g;
    exp_t e;
    cyc++;
    acc_pulse = 1'b0;
    if (rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_req_ready", req_ready, 0);
      q.delete();
      m_idle = 1'b1;
      m_ptr  = 1'b0;
      m_cnt  = '0;
      shown  = 1'b0;
    end else begin
      g = m_idle ? ref_grant(req_valid, m_ptr) : 2'b00;
      chk("busy", busy, !m_idle);
      chk("req_ready", req_ready, g);
      chk("op_count", op_count, m_cnt);
      if (res_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_result: got id=%0d sout=%0h required no result", res_id, res_sout);
        end else begin
          chk("res_id", res_id, q[0].id);
          chk("res_sout", res_sout, q[0].sout);
          if (!shown) begin
            chk("latency", cyc - q[0].acc, 2);
            shown = 1'b1;
          end
          if (res_ready) begin
            void'(q.pop_front());
            m_cnt++;
            m_idle = 1'b1;
            shown  = 1'b0;
          end
        end
      end else if (m_idle && g != 2'b00) begin
        e.id   = g[1];
        e.sout = g[1] ? ref_sub(req1_num1, req1_num2) : ref_sub(req0_num1, req0_num2);
        e.acc  = cyc;
        q.push_back(e);
        m_idle    = 1'b0;
        acc_pulse = 1'b1;
        acc_id    = g[1];
`ifdef SUB_ARB_ROUND_ROBIN_EN
        m_ptr = ~m_ptr;
`endif
      end
    end
  end

  task automatic wait_accept(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (acc_pulse) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept_timeout: got no accept required accept within 20 cycles", nm);
    end
    #1;
  endtask

  task automatic wait_res(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_result_timeout: got res_valid=%0b required 1 within 20 cycles", nm, res_valid);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [15:0] oc;
  logic        exp_ids[4];
  logic [8:0]  exp_souts[4];

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b1;
    req0_num1 = '0; req0_num2 = '0; req1_num1 = '0; req1_num2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester, res_ready high.
    req0_num1 = 8'h80; req0_num2 = 8'h01; req_valid = 2'b01;
    wait_accept("single");
    req_valid = 2'b00; req0_num1 = 8'h55; req0_num2 = 8'hAA;
    wait_res("single");
    chk("single_sout", res_sout, 9'h17F);
    chk("single_id", res_id, 0);
    @(posedge clk); #1;
    chk("single_op_count", op_count, 1);

    // Reset during EXEC discards the operation.
    req0_num1 = 8'h80; req0_num2 = 8'h01; req_valid = 2'b01;
    wait_accept("rstmid");
    rst = 1'b1; req_valid = 2'b00;
    #1;
    chk("rstmid_res_valid", res_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_op_count", op_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Borrow case from requester 1.
    req1_num1 = 8'h40; req1_num2 = 8'h80; req_valid = 2'b10;
    wait_accept("borrow");
    req_valid = 2'b00;
    wait_res("borrow");
    chk("borrow_sout", res_sout, 9'h0C0);
    chk("borrow_id", res_id, 1);
    @(posedge clk); #1;

    // Backpressure: result held, nothing accepted while waiting.
    res_ready = 1'b0;
    req0_num1 = 8'h80; req0_num2 = 8'h80; req_valid = 2'b01;
    wait_accept("bp");
    req_valid = 2'b10; req1_num1 = 8'h09; req1_num2 = 8'h03;
    req0_num1 = 8'h11; req0_num2 = 8'h22;
    wait_res("bp");
    oc = op_count;
    for (int k = 0; k < 5; k++) begin
      chk("bp_sout", res_sout, 9'h100);
      chk("bp_busy", busy, 1);
      chk("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_op_count", op_count, oc + 16'd1);
    wait_accept("bp_next");
    req_valid = 2'b00;
    wait_res("bp_next");
    chk("bp_next_sout", res_sout, 9'h106);
    @(posedge clk); #1;

    // Contention from a fresh reset.
    do_reset();
`ifdef SUB_ARB_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_souts = '{9'h120, 9'h0FF, 9'h120, 9'h0FF};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_souts = '{9'h120, 9'h120, 9'h120, 9'h120};
`endif
    res_ready = 1'b1;
    req0_num1 = 8'h40; req0_num2 = 8'h20; req1_num1 = 8'h01; req1_num2 = 8'h02;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_res("contend");
      chk("contend_id", res_id, exp_ids[k]);
      chk("contend_sout", res_sout, exp_souts[k]);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random backpressure and request withdrawal.
    for (int c = 0; c < 1500; c++) begin
      bit       acc;
      logic     aid;
      @(posedge clk);
      acc = acc_pulse;
      aid = acc_id;
      #1;
      for (int i = 0; i < 2; i++) begin
        if ((acc && aid == i[0]) || !req_valid[i] || $urandom_range(0, 7) == 0) begin
          req_valid[i] = $urandom_range(0, 1) == 1;
          if (i == 0) begin req0_num1 = rnd_op(); req0_num2 = rnd_op(); end
          else        begin req1_num1 = rnd_op(); req1_num2 = rnd_op(); end
        end
      end
      res_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 200) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end

    // Drain.
    req_valid = 2'b00;
    res_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Shares one 8-bit subtraction datapath between two requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block arbitrates, registers the winning operands, computes num1 - num2 and returns a 9-bit result tagged with the requester ID.
- Sits between the ALU front-end clients and the arithmetic unit.
- Tracks busy status and a running count of completed operations.

Parameters:
- WIDTH, 8, operand width in bits; the result is WIDTH+1 bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i has an operand pair pending.
- req_ready  out  2  bit i: requester i is granted; the pair is accepted this edge if req_valid[i] is high.
- req0_num1  in  WIDTH  requester 0 minuend.
- req0_num2  in  WIDTH  requester 0 subtrahend.
- req1_num1  in  WIDTH  requester 1 minuend.
- req1_num2  in  WIDTH  requester 1 subtrahend.
- res_valid  out  1  a result is held on res_sout/res_id.
- res_ready  in  1  consumer takes the result when high together with res_valid.
- res_sout  out  WIDTH+1  bit WIDTH = carry-out (1 = no borrow); bits WIDTH-1:0 = difference.
- res_id  out  1  requester that issued this result.
- busy  out  1  high in EXEC and RESP.
- op_count  out  CNT_W  number of completed result handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous, effective immediately:
  - state=IDLE, req_ready=0, res_valid=0, res_sout=0, res_id=0, busy=0, op_count=0.
  - Priority pointer set to requester 0.
  - An in-flight operation is discarded; no result is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and one-hot: only the arbitration winner among high req_valid bits is driven high; all bits are 0 when no request.
  - On an accept edge: capture num1, num2 and id into internal registers, update the priority pointer, go to EXEC.
- EXEC (one cycle):
  - res_sout <= {1'b0,num1} + {1'b0,~num2} + 1, truncated to WIDTH+1 bits.
  - res_id <= captured id; res_valid <= 1; go to RESP.
- RESP:
  - Hold res_sout and res_id stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready: res_valid <= 0, op_count <= op_count+1, go to IDLE.
- req_ready is 0 in EXEC and RESP; requests are never accepted while busy.
- Latency: accept edge to res_valid high is 2 edges. Minimum issue interval is 3 cycles with res_ready tied high.
- A requester may drop req_valid before acceptance; no state change results.
- Operands are sampled only on the accept edge. Input changes after acceptance do not affect the result.
- Arbitration (default, fixed priority): requester 0 wins whenever req_valid[0]=1. The pointer is unused.
- Both requesters valid with res_ready tied high: requester 0 is served repeatedly and requester 1 starves. This is intended in fixed-priority mode.
- op_count at all-ones wraps to 0 on the next completion.
- A res_ready pulse outside RESP is ignored.

Optional Feature:
- Macro: SUB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The pointer names the preferred requester and is 0 after reset.
  - On each accept, the pointer moves to the other requester.
  - With both valid continuously, grants alternate 0,1,0,1...
  - A single valid requester is always granted regardless of the pointer.
- Not defined: fixed priority to requester 0 as above; the pointer register is not built.

Test Plan:
- Reset mid-operation: accept req0 (0x80,0x01), assert rst during EXEC -> res_valid=0, busy=0, op_count=0 immediately; no result is ever output for that operation.
- Single requester: req0 (num1=0x80, num2=0x01), res_ready=1 -> res_sout=9'h17F, res_id=0, res_valid high 2 edges after accept, op_count=1.
- Borrow case: req1 (num1=0x40, num2=0x80) -> res_sout=9'h0C0 (carry 0), res_id=1.
- Backpressure: req0 (0x80,0x80), res_ready=0 for 5 cycles -> res_sout=9'h100 held stable, busy=1, req_ready=2'b00 throughout; release -> op_count increments once, next request accepted.
- Contention, 4 operations, both valid, res_ready=1, req0 (0x40,0x20) and req1 (0x01,0x02):
  - Without the macro -> four results all res_id=0, res_sout=9'h120.
  - With SUB_ARB_ROUND_ROBIN_EN -> res_id sequence 0,1,0,1 with res_sout 9'h120, 9'h0FF alternating.
